juego_led_control: RTL

//  Game sequencer for the LED reaction game. It produces the 2-bit `numero` code that drives CodificadorLed:
//   0 = all off, 1 = red (fail), 2 = green (go / hit), 3 = all on (end of game).
//  Per round: wait a pseudo-random delay, light green, then check that the player presses `boton` within the window.

---
 rtl/juego_led_control_pkg.sv | 46 ++++
 rtl/juego_led_control_if.sv | 20 ++
 rtl/juego_led_control_sincroniza_pulso.sv | 29 ++
 rtl/juego_led_control.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/juego_led_control_pkg.sv
// Shared definitions for the LED reaction game: FSM state encoding, LED codes
// for the LED encoder, and small helpers used by the sequencer.
package juego_led_defs;

  typedef enum logic [2:0] {
    REPOSO  = 3'd0,
    ESPERA  = 3'd1,
    VENTANA = 3'd2,
    ACIERTO = 3'd3,
    FALLO   = 3'd4,
    NEXT    = 3'd5,
    FIN     = 3'd6
  } estado_e;

  localparam logic [1:0] LED_APAGADO = 2'd0;
  localparam logic [1:0] LED_ROJO    = 2'd1;
  localparam logic [1:0] LED_VERDE   = 2'd2;
  localparam logic [1:0] LED_FIN     = 2'd3;

  localparam logic [7:0] LFSR_SEMILLA = 8'h5A;

  // Fibonacci step for x^8+x^6+x^5+x^4+1; maximal length, so a non-zero seed never reaches 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [1:0] led_de_estado(input estado_e s);
    logic [1:0] led;
    case (s)
      VENTANA, ACIERTO: led = LED_VERDE;
      FALLO:            led = LED_ROJO;
      FIN:              led = LED_FIN;
      default:          led = LED_APAGADO;
    endcase
    return led;
  endfunction

  function automatic logic ocupado_de_estado(input estado_e s);
    return (s != REPOSO) && (s != FIN);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/juego_led_control_if.sv
// Player/board-side signals of the game sequencer: the two push-buttons in,
// LED code and score out.
interface juego_led_control_if;
  logic       start;
  logic       boton;
  logic [1:0] numero;
  logic [3:0] aciertos;
  logic [3:0] ronda;
  logic       ocupado;

  modport master (
    output start, boton,
    input  numero, aciertos, ronda, ocupado
  );

  modport slave (
    input  start, boton,
    output numero, aciertos, ronda, ocupado
  );
endinterface

// File: rtl/juego_led_control_sincroniza_pulso.sv
// Brings an asynchronous push-button into the clk domain and turns each rising
// edge into a single-cycle pulse; a held button yields one pulse only.
module sincroniza_pulso (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic pulso_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Two metastability flops followed by the edge-history register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign pulso_o = sync2_q & ~prev_q;

endmodule

// File: rtl/juego_led_control.sv
// Reaction-game sequencer: random wait, green window, hit/miss display per round,
// end code after ROUNDS rounds. numero feeds the external LED encoder directly.
module juego_led_control
  import juego_led_defs::*;
#(
  parameter int WAIT_MIN  = 16,
  parameter int WAIT_MASK = 15,
  parameter int WINDOW    = 8,
  parameter int SHOW      = 8,
  parameter int ROUNDS    = 4
) (
  input  logic              clk,
  input  logic              rst,
  juego_led_control_if.slave bus_if
);

  localparam int CNT_MAX = max_int(max_int(WAIT_MIN + WAIT_MASK, WINDOW), SHOW);
  localparam int CNT_W   = max_int(9, $clog2(CNT_MAX + 1));

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t       CNT_UNO    = cnt_t'(1);
  localparam cnt_t       WAIT_MIN_C = cnt_t'(WAIT_MIN);
  localparam cnt_t       MASK_C     = cnt_t'(WAIT_MASK);
  localparam cnt_t       WINDOW_C   = cnt_t'(WINDOW);
  localparam cnt_t       SHOW_C     = cnt_t'(SHOW);
  localparam logic [3:0] ROUNDS_C   = 4'(ROUNDS);

  estado_e    state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [3:0] aciertos_q, aciertos_d;
  logic [3:0] ronda_q, ronda_d;
  logic [7:0] lfsr_q;
  logic [1:0] numero_q;
  logic       ocupado_q;

  logic       start_pulso;
  logic       boton_pulso;
  cnt_t       retardo;

  sincroniza_pulso u_sync_start (
    .clk     (clk),
    .rst     (rst),
    .pin_i   (bus_if.start),
    .pulso_o (start_pulso)
  );

  sincroniza_pulso u_sync_boton (
    .clk     (clk),
    .rst     (rst),
    .pin_i   (bus_if.boton),
    .pulso_o (boton_pulso)
  );

  assign retardo = WAIT_MIN_C + (cnt_t'(lfsr_q) & MASK_C);

  // Next-state logic; a button press takes priority over the counter expiring.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    aciertos_d = aciertos_q;
    ronda_d    = ronda_q;
    case (state_q)
      REPOSO, FIN: begin
        if (start_pulso) begin
          aciertos_d = 4'd0;
          ronda_d    = 4'd0;
          cnt_d      = retardo;
          state_d    = ESPERA;
        end else begin
          state_d = state_q;
        end
      end
      ESPERA: begin
        if (boton_pulso) begin
          cnt_d   = SHOW_C;
          state_d = FALLO;
        end else if (cnt_q == CNT_UNO) begin
          cnt_d   = WINDOW_C;
          state_d = VENTANA;
        end else begin
          cnt_d = cnt_q - CNT_UNO;
        end
      end
      VENTANA: begin
        if (boton_pulso) begin
          aciertos_d = aciertos_q + 4'd1;
          cnt_d      = SHOW_C;
          state_d    = ACIERTO;
        end else if (cnt_q == CNT_UNO) begin
          cnt_d   = SHOW_C;
          state_d = FALLO;
        end else begin
          cnt_d = cnt_q - CNT_UNO;
        end
      end
      ACIERTO, FALLO: begin
        if (cnt_q == CNT_UNO) begin
          ronda_d = ronda_q + 4'd1;
          cnt_d   = '0;
          state_d = NEXT;
        end else begin
          cnt_d = cnt_q - CNT_UNO;
        end
      end
      NEXT: begin
        if (ronda_q == ROUNDS_C) begin
          state_d = FIN;
        end else begin
          cnt_d   = retardo;
          state_d = ESPERA;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = REPOSO;
      end
    endcase
  end

  // State, counters and LFSR; LED code and busy flag are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= REPOSO;
      cnt_q      <= '0;
      aciertos_q <= 4'd0;
      ronda_q    <= 4'd0;
      lfsr_q     <= LFSR_SEMILLA;
      numero_q   <= LED_APAGADO;
      ocupado_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      aciertos_q <= aciertos_d;
      ronda_q    <= ronda_d;
      lfsr_q     <= lfsr_next(lfsr_q);
      numero_q   <= led_de_estado(state_d);
      ocupado_q  <= ocupado_de_estado(state_d);
    end
  end

  assign bus_if.numero   = numero_q;
  assign bus_if.aciertos = aciertos_q;
  assign bus_if.ronda    = ronda_q;
  assign bus_if.ocupado  = ocupado_q;

endmodule
